main_ram_arbiter: RTL and testbench
===================================

MAIN_RAM_ARBITER -- requirements
Module: main_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, word-address width shared by both requesters and the RAM port.
REQ-002 Parameter DATA_W, default 16, data width; byte-enable width SHALL be DATA_W/8.
REQ-003 Parameter ROUND_ROBIN, default 1; 1 = alternate on contention, 0 = port A fixed priority.
REQ-004 clk  in  1  single system clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 a_req / b_req  in  1  access request, held until matching ack.
REQ-007 a_write / b_write  in  1  1 = write, 0 = read; stable while req high.
REQ-008 a_addr / b_addr  in  ADDR_W  word address; stable while req high.
REQ-009 a_wdata / b_wdata  in  DATA_W  write data; stable while req high.
REQ-010 a_be / b_be  in  DATA_W/8  byte enables; stable while req high.
REQ-011 a_ack / b_ack  out  1  one-cycle completion pulse.
REQ-012 a_rdata / b_rdata  out  DATA_W  read data, valid in ack cycle of a read.
REQ-013 ram_address  out  ADDR_W, ram_byteenable  out  DATA_W/8, ram_writedata  out  DATA_W: registered RAM command.
REQ-014 ram_chipselect  out  1, ram_write  out  1: registered RAM strobes.
REQ-015 ram_clken  out  1  RAM clock enable, constant 1 out of reset.
REQ-016 ram_readdata  in  DATA_W  RAM output; valid the cycle after the RAM samples its address.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, CMD, DATA, ACK; every transition advances one per clock except IDLE.
REQ-019 IDLE: if any req high, SHALL select a winner, register its addr/be/wdata onto ram_*, assert ram_chipselect, set ram_write = winner's write, latch winner id, go CMD; else stay IDLE with ram_chipselect = ram_write = 0.
REQ-020 Contention with ROUND_ROBIN=1: grant port not granted last; last_grant register updates on every grant.
REQ-021 Contention with ROUND_ROBIN=0: port A always wins.
REQ-022 CMD: ram_* hold command for exactly this cycle (RAM captures at end of CMD); next state DATA.
REQ-023 DATA: ram_chipselect = ram_write = 0; on a read, winner's rdata register SHALL load ram_readdata; next state ACK.
REQ-024 ACK: winner's ack = 1 for exactly this cycle; other ack = 0; next state IDLE.
REQ-025 Request sampled in IDLE only; a req still high in ACK SHALL NOT be granted before the following IDLE cycle.
REQ-026 Latency: req seen in IDLE cycle N -> ack in cycle N+3; one access per 4 cycles maximum.
REQ-027 On writes, rdata of the winner SHALL keep its previous value.
REQ-028 Loser rdata and ack SHALL be unaffected by the other port's transaction.
REQ-029 req deasserted mid-transaction: transaction SHALL complete and ack SHALL still pulse.
REQ-030 ram_write SHALL never be high while ram_chipselect is low.

Reset
REQ-031 While reset high: state IDLE, last_grant = B (so A wins first contention), ram_chipselect = ram_write = 0, ram_address/byteenable/writedata = 0, ram_clken = 0, acks = 0, rdata = 0, busy = 0.
REQ-032 Reset asserted mid-transaction SHALL abort it immediately with no ack issued; ram_clken SHALL rise the first clock after reset release.

Verification
REQ-033 A read only: a_req=1, a_addr=0x0100, RAM holds 0xBEEF -> ram_chipselect high 1 cycle, a_ack in cycle N+3, a_rdata=0xBEEF.
REQ-034 B write: b_addr=0x0010, b_wdata=0x1234, b_be=2'b01 -> ram_write=1 one cycle with byteenable 01; subsequent B read returns low byte 0x34 in byte 0.
REQ-035 Both req held continuously, ROUND_ROBIN=1 -> grants A,B,A,B; acks every 4 cycles alternating, first to A.
REQ-036 Same with ROUND_ROBIN=0 -> only A acked while a_req high; B acked first IDLE after a_req drops.
REQ-037 reset pulsed during DATA of an A read -> no a_ack, all outputs at reset values, next request completes normally in 3 cycles.
REQ-038 a_req dropped in CMD -> a_ack still pulses in ACK; no new grant afterwards.

Source files
------------

// File: rtl/main_ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Each access takes four cycles: IDLE (grant), CMD, DATA and ACK.
module main_ram_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_req,
    input  logic                a_write,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    input  logic [DATA_W/8-1:0] a_be,
    output logic                a_ack,
    output logic [DATA_W-1:0]   a_rdata,
    input  logic                b_req,
    input  logic                b_write,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    input  logic [DATA_W/8-1:0] b_be,
    output logic                b_ack,
    output logic [DATA_W-1:0]   b_rdata,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, ACK} state_t;

    state_t state;
    state_t state_next;
    logic   winner;
    logic   last_grant;
    logic   txn_write;
    logic   grant_b;

    // Port ids: 0 = A, 1 = B. B wins when alone, or on contention when A was served last.
    assign grant_b = b_req && (!a_req || ((ROUND_ROBIN != 0) && !last_grant));

    assign a_ack = (state == ACK) && !winner;
    assign b_ack = (state == ACK) && winner;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (a_req || b_req) state_next = CMD;
            CMD:     state_next = DATA;
            DATA:    state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The transaction kind is kept separately because ram_write drops after CMD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_address    <= '0;
            ram_byteenable <= '0;
            ram_writedata  <= '0;
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;
            ram_clken      <= 1'b0;
            winner         <= 1'b0;
            last_grant     <= 1'b1;
            txn_write      <= 1'b0;
            a_rdata        <= '0;
            b_rdata        <= '0;
        end else begin
            ram_clken <= 1'b1;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        ram_address    <= grant_b ? b_addr  : a_addr;
                        ram_byteenable <= grant_b ? b_be    : a_be;
                        ram_writedata  <= grant_b ? b_wdata : a_wdata;
                        ram_chipselect <= 1'b1;
                        ram_write      <= grant_b ? b_write : a_write;
                        txn_write      <= grant_b ? b_write : a_write;
                        winner         <= grant_b;
                        last_grant     <= grant_b;
                    end else begin
                        ram_chipselect <= 1'b0;
                        ram_write      <= 1'b0;
                    end
                end
                CMD: begin
                    ram_chipselect <= 1'b0;
                    ram_write      <= 1'b0;
                end
                DATA: begin
                    if (!txn_write) begin
                        if (winner) begin
                            b_rdata <= ram_readdata;
                        end else begin
                            a_rdata <= ram_readdata;
                        end
                    end
                end
                ACK: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_ram_arbiter.sv
// Scoreboard bench for main_ram_arbiter: a round-robin instance on a byte-enabled RAM
// model and a fixed-priority instance on a RAM that returns address ^ 16'hA5A5.
module tb_main_ram_arbiter;

    typedef struct {
        int          port;
        logic        is_read;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0, a_write = 1'b0, b_req = 1'b0, b_write = 1'b0;
    logic [15:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic [1:0]  a_be = '0, b_be = '0;
    logic        a_ack, b_ack, busy;
    logic [15:0] a_rdata, b_rdata;
    logic [15:0] ram_address, ram_writedata, ram_readdata;
    logic [1:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;

    logic        fa_req = 1'b0, fb_req = 1'b0;
    logic        fa_ack, fb_ack, f_busy;
    logic [15:0] fa_rdata, fb_rdata;
    logic [15:0] f_ram_address, f_ram_writedata, f_ram_readdata;
    logic [1:0]  f_ram_byteenable;
    logic        f_ram_chipselect, f_ram_write, f_ram_clken;

    logic        preload_en = 1'b0;
    logic [15:0] preload_addr = '0, preload_data = '0;
    logic [15:0] mem [0:1023];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    main_ram_arbiter #(.ADDR_W(16), .DATA_W(16), .ROUND_ROBIN(1)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata), .busy(busy)
    );

    main_ram_arbiter #(.ADDR_W(16), .DATA_W(16), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .reset(reset),
        .a_req(fa_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_ack(fa_ack), .a_rdata(fa_rdata),
        .b_req(fb_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_ack(fb_ack), .b_rdata(fb_rdata),
        .ram_address(f_ram_address), .ram_byteenable(f_ram_byteenable),
        .ram_writedata(f_ram_writedata), .ram_chipselect(f_ram_chipselect),
        .ram_write(f_ram_write), .ram_clken(f_ram_clken),
        .ram_readdata(f_ram_readdata), .busy(f_busy)
    );

    // RAM model: captures on the clock edge that ends CMD, read data valid in DATA.
    always @(posedge clk) begin
        if (preload_en) begin
            mem[preload_addr[9:0]] <= preload_data;
        end else if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                if (ram_byteenable[0]) mem[ram_address[9:0]][7:0]  <= ram_writedata[7:0];
                if (ram_byteenable[1]) mem[ram_address[9:0]][15:8] <= ram_writedata[15:8];
            end else begin
                ram_readdata <= mem[ram_address[9:0]];
            end
        end
    end

    always @(posedge clk) begin
        if (f_ram_clken && f_ram_chipselect && !f_ram_write)
            f_ram_readdata <= f_ram_address ^ 16'hA5A5;
    end

    always @(negedge clk) begin
        if (!reset) begin
            n_checks++;
            if ((ram_write && !ram_chipselect) || (f_ram_write && !f_ram_chipselect)) begin
                n_fail++;
                $display("[TB] FAIL strobe_order: write=%b cs=%b fp_write=%b fp_cs=%b required write only with cs",
                         ram_write, ram_chipselect, f_ram_write, f_ram_chipselect);
            end
            n_checks++;
            if ((a_ack && b_ack) || (fa_ack && fb_ack)) begin
                n_fail++;
                $display("[TB] FAIL dual_ack: a=%b b=%b fa=%b fb=%b required at most one ack",
                         a_ack, b_ack, fa_ack, fb_ack);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] addr, input logic [15:0] data);
        preload_en   = 1'b1;
        preload_addr = addr;
        preload_data = data;
        tick();
        preload_en   = 1'b0;
    endtask

    task automatic start_req(input int port, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [1:0] be,
                             input logic [15:0] exp_data);
        exp_t e;
        if (port == 0) begin
            a_write = wr; a_addr = addr; a_wdata = wdata; a_be = be; a_req = 1'b1;
        end else begin
            b_write = wr; b_addr = addr; b_wdata = wdata; b_be = be; b_req = 1'b1;
        end
        e.port = port; e.is_read = !wr; e.data = exp_data;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int limit, input logic fp, output int port,
                            output logic [15:0] data, output int cycles);
        bit done = 0;
        port = -1; data = '0; cycles = 0;
        for (int i = 1; i <= limit && !done; i++) begin
            tick();
            if (fp ? fa_ack : a_ack) begin
                port = 0; data = fp ? fa_rdata : a_rdata; cycles = i; done = 1;
            end else if (fp ? fb_ack : b_ack) begin
                port = 1; data = fp ? fb_rdata : b_rdata; cycles = i; done = 1;
            end
        end
    endtask

    task automatic pop_expected(output exp_t e);
        e.port = -2; e.is_read = 1'b0; e.data = '0;
        if (sb.size() > 0) e = sb.pop_front();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++;
        if ({ram_chipselect, ram_write, ram_clken, a_ack, b_ack, busy} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_strobes: got %b required 000000",
                     {ram_chipselect, ram_write, ram_clken, a_ack, b_ack, busy});
        end
        n_checks++;
        if ({ram_address, ram_byteenable, ram_writedata} !== 34'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_cmd: got %h required 0", {ram_address, ram_byteenable, ram_writedata});
        end
        n_checks++;
        if ({a_rdata, b_rdata} !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_rdata: got %h required 0", {a_rdata, b_rdata});
        end
        reset = 1'b0;
        n_checks++;
        if (ram_clken !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clken_before_edge: got %b required 0", ram_clken);
        end
        tick();
        n_checks++;
        if (ram_clken !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clken_after_edge: got %b required 1", ram_clken);
        end
    endtask

    task automatic test_read_a();
        int port, cycles;
        logic [15:0] data;
        exp_t e;
        preload(16'h0100, 16'hBEEF);
        start_req(0, 1'b0, 16'h0100, 16'h0000, 2'b11, 16'hBEEF);
        tick();
        n_checks++;
        if ({ram_chipselect, ram_write, ram_address} !== {2'b10, 16'h0100}) begin
            n_fail++;
            $display("[TB] FAIL read_cmd: got cs=%b wr=%b addr=%h required cs=1 wr=0 addr=0100",
                     ram_chipselect, ram_write, ram_address);
        end
        tick();
        n_checks++;
        if (ram_chipselect !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL read_cs_one_cycle: got %b required 0", ram_chipselect);
        end
        wait_ack(8, 1'b0, port, data, cycles);
        a_req = 1'b0;
        pop_expected(e);
        n_checks++;
        if (port !== e.port || cycles !== 1) begin
            n_fail++;
            $display("[TB] FAIL read_ack: got port %0d after %0d required port %0d after 1", port, cycles, e.port);
        end
        n_checks++;
        if (data !== e.data) begin
            n_fail++;
            $display("[TB] FAIL read_data: got %h required %h", data, e.data);
        end
        tick();
    endtask

    task automatic test_write_b();
        int port, cycles;
        logic [15:0] data;
        exp_t e;
        preload(16'h0010, 16'hAAAA);
        preload(16'h0020, 16'h5A5A);
        start_req(1, 1'b0, 16'h0020, 16'h0000, 2'b11, 16'h5A5A);
        wait_ack(8, 1'b0, port, data, cycles);
        b_req = 1'b0;
        pop_expected(e);
        n_checks++;
        if (port !== e.port || data !== e.data || cycles !== 3) begin
            n_fail++;
            $display("[TB] FAIL b_read: got port %0d data %h lat %0d required port %0d data %h lat 3",
                     port, data, cycles, e.port, e.data);
        end
        n_checks++;
        if (a_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("[TB] FAIL a_rdata_isolated: got %h required BEEF", a_rdata);
        end
        tick();
        start_req(1, 1'b1, 16'h0010, 16'h1234, 2'b01, 16'h0000);
        tick();
        n_checks++;
        if ({ram_chipselect, ram_write, ram_byteenable, ram_address, ram_writedata} !==
            {2'b11, 2'b01, 16'h0010, 16'h1234}) begin
            n_fail++;
            $display("[TB] FAIL write_cmd: got cs=%b wr=%b be=%b addr=%h wd=%h required 1 1 01 0010 1234",
                     ram_chipselect, ram_write, ram_byteenable, ram_address, ram_writedata);
        end
        tick();
        n_checks++;
        if (ram_write !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL write_one_cycle: got %b required 0", ram_write);
        end
        wait_ack(8, 1'b0, port, data, cycles);
        b_req = 1'b0;
        pop_expected(e);
        n_checks++;
        if (port !== e.port || data !== 16'h5A5A) begin
            n_fail++;
            $display("[TB] FAIL write_ack_keeps_rdata: got port %0d data %h required port 1 data 5a5a", port, data);
        end
        tick();
        start_req(1, 1'b0, 16'h0010, 16'h0000, 2'b11, 16'hAA34);
        wait_ack(8, 1'b0, port, data, cycles);
        b_req = 1'b0;
        pop_expected(e);
        n_checks++;
        if (port !== e.port || data !== e.data) begin
            n_fail++;
            $display("[TB] FAIL b_readback: got port %0d data %h required port %0d data %h", port, data, e.port, e.data);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int port, cycles;
        logic [15:0] data;
        exp_t e;
        preload(16'h0200, 16'h1111);
        preload(16'h0300, 16'h2222);
        for (int i = 0; i < 2; i++) begin
            start_req(0, 1'b0, 16'h0200, 16'h0000, 2'b11, 16'h1111);
            start_req(1, 1'b0, 16'h0300, 16'h0000, 2'b11, 16'h2222);
        end
        for (int i = 0; i < 4; i++) begin
            wait_ack(12, 1'b0, port, data, cycles);
            pop_expected(e);
            n_checks++;
            if (port !== e.port || data !== e.data || cycles !== (i == 0 ? 3 : 4)) begin
                n_fail++;
                $display("[TB] FAIL rr_grant%0d: got port %0d data %h gap %0d required port %0d data %h gap %0d",
                         i, port, data, cycles, e.port, e.data, (i == 0 ? 3 : 4));
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_fixed_priority();
        int port, cycles;
        logic [15:0] data;
        exp_t e;
        a_write = 1'b0; a_addr = 16'h0200; b_write = 1'b0; b_addr = 16'h0300;
        for (int i = 0; i < 4; i++) begin
            e.port = (i < 3) ? 0 : 1;
            e.is_read = 1'b1;
            e.data = ((i < 3) ? 16'h0200 : 16'h0300) ^ 16'hA5A5;
            sb.push_back(e);
        end
        fa_req = 1'b1;
        fb_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(12, 1'b1, port, data, cycles);
            if (i == 2) fa_req = 1'b0;
            pop_expected(e);
            n_checks++;
            if (port !== e.port || data !== e.data || cycles !== (i == 0 ? 3 : 4)) begin
                n_fail++;
                $display("[TB] FAIL fp_grant%0d: got port %0d data %h gap %0d required port %0d data %h gap %0d",
                         i, port, data, cycles, e.port, e.data, (i == 0 ? 3 : 4));
            end
        end
        fb_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        int port, cycles;
        logic [15:0] data;
        exp_t e;
        a_write = 1'b0; a_addr = 16'h0100; a_be = 2'b11; a_req = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_busy: got %b required 1", busy);
        end
        reset = 1'b1;
        a_req = 1'b0;
        #1;
        n_checks++;
        if ({busy, ram_chipselect, ram_write, ram_clken, a_ack, ram_address, ram_byteenable, ram_writedata, a_rdata}
            !== 55'h0) begin
            n_fail++;
            $display("[TB] FAIL abort_outputs: busy=%b cs=%b wr=%b clken=%b ack=%b addr=%h be=%b wd=%h rdata=%h required all 0",
                     busy, ram_chipselect, ram_write, ram_clken, a_ack, ram_address, ram_byteenable,
                     ram_writedata, a_rdata);
        end
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (ram_clken !== 1'b1 || a_ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL after_abort: got clken=%b ack=%b required clken=1 ack=0", ram_clken, a_ack);
        end
        start_req(0, 1'b0, 16'h0100, 16'h0000, 2'b11, 16'hBEEF);
        wait_ack(8, 1'b0, port, data, cycles);
        a_req = 1'b0;
        pop_expected(e);
        n_checks++;
        if (port !== e.port || data !== e.data || cycles !== 3) begin
            n_fail++;
            $display("[TB] FAIL post_reset_read: got port %0d data %h lat %0d required port %0d data %h lat 3",
                     port, data, cycles, e.port, e.data);
        end
        tick();
    endtask

    task automatic test_drop_in_cmd();
        int port, cycles;
        logic [15:0] data;
        exp_t e;
        logic extra = 1'b0;
        start_req(0, 1'b0, 16'h0200, 16'h0000, 2'b11, 16'h1111);
        tick();
        a_req = 1'b0;
        tick();
        wait_ack(4, 1'b0, port, data, cycles);
        pop_expected(e);
        n_checks++;
        if (port !== e.port || data !== e.data || cycles !== 1) begin
            n_fail++;
            $display("[TB] FAIL drop_ack: got port %0d data %h after %0d required port %0d data %h after 1",
                     port, data, cycles, e.port, e.data);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            extra = extra | a_ack | b_ack | busy;
            tick();
        end
        n_checks++;
        if (extra !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL drop_no_regrant: got activity %b required 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_read_a();
        test_write_b();
        test_round_robin();
        test_fixed_priority();
        test_reset_mid();
        test_drop_in_cmd();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
